// File: rtl/interboard_tx_handshake_pkg.sv
// -----------------------------------------------------------------------------
// interboard_tx_handshake_pkg
// Shared definitions for the board-to-board link: handshake FSM states, the
// game-control message layout and its packing into four 6-bit chunks. The
// receive path imports the same package to unpack chunks back into a message.
// -----------------------------------------------------------------------------
package interboard_tx_handshake_pkg;

    localparam int CHUNKS  = 4;
    localparam int CHUNK_W = 6;

    // Field positions inside each chunk (LSB offsets, MSB-first packing)
    localparam int C0_TYPE_LSB = 2;
    localparam int C0_EN_BIT   = 1;
    localparam int C0_DIR_BIT  = 0;
    localparam int C1_CARD_LSB = 0;
    localparam int C2_Y_LSB    = 3;
    localparam int C2_LEN_LSB  = 0;
    localparam int C3_X_LSB    = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_REQ_HI = 3'd2,
        ST_REQ_LO = 3'd3,
        ST_DONE   = 3'd4,
        ST_ABORT  = 3'd5
    } tx_state_t;

    typedef struct packed {
        logic       en;
        logic       move_dir;
        logic [4:0] block_x;
        logic [2:0] block_y;
        logic [3:0] msg_type;
        logic [5:0] card;
        logic [2:0] sel_len;
    } ctrl_msg_t;

    // Returns chunk idx of message m; chunk3 carries a zero pad in bit 0.
    function automatic logic [CHUNK_W-1:0] pack_chunk(input ctrl_msg_t m,
                                                      input logic [1:0] idx);
        logic [CHUNK_W-1:0] c;
        c = '0;
        case (idx)
            2'd0: begin
                c[C0_TYPE_LSB +: 4] = m.msg_type;
                c[C0_EN_BIT]        = m.en;
                c[C0_DIR_BIT]       = m.move_dir;
            end
            2'd1: c[C1_CARD_LSB +: 6] = m.card;
            2'd2: begin
                c[C2_Y_LSB +: 3]   = m.block_y;
                c[C2_LEN_LSB +: 3] = m.sel_len;
            end
            2'd3: c[C3_X_LSB +: 5] = m.block_x;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/interboard_tx_handshake_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous level (Ack on the transmit
// side, Request on the receive side). Output lags the input by two clocks.
// Ports: clk, rst (async active-high, clears to 0), d (async in), q (synced).
// -----------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/interboard_tx_handshake.sv
// -----------------------------------------------------------------------------
// interboard_tx_handshake
// Transmit side of the board-to-board link. On a transmit pulse the control
// fields are latched and sent as four 6-bit chunks, each with a four-phase
// Request/Ack handshake. All outputs are registered.
// Ports:
//   clk, rst                 clock, async active-high reset
//   transmit                 one-cycle send request
//   ctrl_*                   message fields latched on transmit
//   ack_in                   raw Ack pin (asynchronous)
//   req_out, data_out        Request / data pin drive values
//   data_oe                  this board drives Request and data pins
//   busy                     message in progress
//   tx_done, tx_error        one-cycle completion / timeout pulses
//   tx_overrun               one-cycle pulse: transmit dropped while busy
// -----------------------------------------------------------------------------
module interboard_tx_handshake
    import interboard_tx_handshake_pkg::*;
#(
    parameter int SETUP_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int CHUNKS         = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       transmit,
    input  logic       ctrl_en,
    input  logic       ctrl_move_dir,
    input  logic [4:0] ctrl_block_x,
    input  logic [2:0] ctrl_block_y,
    input  logic [3:0] ctrl_msg_type,
    input  logic [5:0] ctrl_card,
    input  logic [2:0] ctrl_sel_len,
    input  logic       ack_in,
    output logic       req_out,
    output logic [5:0] data_out,
    output logic       data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error,
    output logic       tx_overrun
);

    localparam int SCNT_W = $clog2(SETUP_CYCLES + 1);
    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SCNT_W-1:0] SETUP_LAST = SCNT_W'(SETUP_CYCLES - 1);
    localparam logic [SCNT_W-1:0] SETUP_MAX  = SCNT_W'(SETUP_CYCLES);
    localparam logic [TCNT_W-1:0] TOUT_LAST  = TCNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TCNT_W-1:0] TOUT_MAX   = TCNT_W'(TIMEOUT_CYCLES);
    localparam logic [1:0]        IDX_LAST   = 2'(CHUNKS - 1);

    tx_state_t         state_r, state_nxt_s;
    logic              ack_s;
    ctrl_msg_t         in_msg_s;
    ctrl_msg_t         msg_r, msg_nxt_s;
    logic [1:0]        idx_r, idx_nxt_s;
    logic [SCNT_W-1:0] scnt_r, scnt_nxt_s;
    logic [TCNT_W-1:0] tcnt_r, tcnt_nxt_s;
    logic              req_r, req_nxt_s;
    logic [5:0]        data_r, data_nxt_s;
    logic              oe_r, oe_nxt_s;
    logic              busy_r, busy_nxt_s;
    logic              done_r, done_nxt_s;
    logic              error_r, error_nxt_s;
    logic              overrun_r, overrun_nxt_s;
    logic              scnt_step_s;
    logic              setup_done_s;
    logic              timeout_s;

    sync_2ff u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d   (ack_in),
        .q   (ack_s)
    );

    assign in_msg_s = '{en:       ctrl_en,
                        move_dir: ctrl_move_dir,
                        block_x:  ctrl_block_x,
                        block_y:  ctrl_block_y,
                        msg_type: ctrl_msg_type,
                        card:     ctrl_card,
                        sel_len:  ctrl_sel_len};

    // The setup count may only leave zero once the peer has released Ack;
    // after that it runs to completion regardless of Ack.
    assign scnt_step_s  = (scnt_r != '0) || !ack_s;
    assign setup_done_s = scnt_step_s && (scnt_r == SETUP_LAST);
    // Fires on the cycle whose edge completes TIMEOUT_CYCLES of waiting
    assign timeout_s    = (tcnt_r >= TOUT_LAST);

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (transmit) state_nxt_s = ST_SETUP;
                else          state_nxt_s = ST_IDLE;
            end
            ST_SETUP: begin
                if (setup_done_s) state_nxt_s = ST_REQ_HI;
                else              state_nxt_s = ST_SETUP;
            end
            ST_REQ_HI: begin
                if (ack_s)          state_nxt_s = ST_REQ_LO;
                else if (timeout_s) state_nxt_s = ST_ABORT;
                else                state_nxt_s = ST_REQ_HI;
            end
            ST_REQ_LO: begin
                if (!ack_s) begin
                    if (idx_r == IDX_LAST) state_nxt_s = ST_DONE;
                    else                   state_nxt_s = ST_SETUP;
                end else if (timeout_s) begin
                    state_nxt_s = ST_ABORT;
                end else begin
                    state_nxt_s = ST_REQ_LO;
                end
            end
            ST_DONE:  state_nxt_s = ST_IDLE;
            ST_ABORT: state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Next values of datapath and output registers
    always_comb begin
        msg_nxt_s     = msg_r;
        idx_nxt_s     = idx_r;
        scnt_nxt_s    = scnt_r;
        tcnt_nxt_s    = tcnt_r;
        req_nxt_s     = req_r;
        data_nxt_s    = data_r;
        oe_nxt_s      = oe_r;
        busy_nxt_s    = busy_r;
        done_nxt_s    = 1'b0;
        error_nxt_s   = 1'b0;
        // DONE and ABORT still count as busy, so a request there is dropped too
        overrun_nxt_s = transmit && (state_r != ST_IDLE);
        case (state_r)
            ST_IDLE: begin
                if (transmit) begin
                    msg_nxt_s  = in_msg_s;
                    idx_nxt_s  = 2'd0;
                    scnt_nxt_s = '0;
                    busy_nxt_s = 1'b1;
                    oe_nxt_s   = 1'b1;
                    data_nxt_s = pack_chunk(in_msg_s, 2'd0);
                end else begin
                    scnt_nxt_s = '0;
                end
            end
            ST_SETUP: begin
                if (setup_done_s) begin
                    req_nxt_s  = 1'b1;
                    tcnt_nxt_s = '0;
                end else if (scnt_step_s && (scnt_r != SETUP_MAX)) begin
                    scnt_nxt_s = scnt_r + SCNT_W'(1);
                end else begin
                    scnt_nxt_s = scnt_r;
                end
            end
            ST_REQ_HI: begin
                if (ack_s) begin
                    req_nxt_s  = 1'b0;
                    tcnt_nxt_s = '0;
                end else if (timeout_s) begin
                    // Release Request as soon as the link is abandoned
                    req_nxt_s   = 1'b0;
                    error_nxt_s = 1'b1;
                end else if (tcnt_r != TOUT_MAX) begin
                    tcnt_nxt_s = tcnt_r + TCNT_W'(1);
                end else begin
                    tcnt_nxt_s = tcnt_r;
                end
            end
            ST_REQ_LO: begin
                if (!ack_s) begin
                    if (idx_r == IDX_LAST) begin
                        done_nxt_s = 1'b1;
                    end else begin
                        idx_nxt_s  = idx_r + 2'd1;
                        scnt_nxt_s = '0;
                        data_nxt_s = pack_chunk(msg_r, idx_r + 2'd1);
                    end
                end else if (timeout_s) begin
                    error_nxt_s = 1'b1;
                end else if (tcnt_r != TOUT_MAX) begin
                    tcnt_nxt_s = tcnt_r + TCNT_W'(1);
                end else begin
                    tcnt_nxt_s = tcnt_r;
                end
            end
            ST_DONE, ST_ABORT: begin
                req_nxt_s  = 1'b0;
                busy_nxt_s = 1'b0;
                oe_nxt_s   = 1'b0;
                data_nxt_s = 6'd0;
                idx_nxt_s  = 2'd0;
                scnt_nxt_s = '0;
                tcnt_nxt_s = '0;
            end
            default: begin
                req_nxt_s  = 1'b0;
                busy_nxt_s = 1'b0;
                oe_nxt_s   = 1'b0;
                data_nxt_s = 6'd0;
                idx_nxt_s  = 2'd0;
                scnt_nxt_s = '0;
                tcnt_nxt_s = '0;
            end
        endcase
    end

    // Datapath, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msg_r     <= '0;
            idx_r     <= 2'd0;
            scnt_r    <= '0;
            tcnt_r    <= '0;
            req_r     <= 1'b0;
            data_r    <= 6'd0;
            oe_r      <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            error_r   <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            msg_r     <= msg_nxt_s;
            idx_r     <= idx_nxt_s;
            scnt_r    <= scnt_nxt_s;
            tcnt_r    <= tcnt_nxt_s;
            req_r     <= req_nxt_s;
            data_r    <= data_nxt_s;
            oe_r      <= oe_nxt_s;
            busy_r    <= busy_nxt_s;
            done_r    <= done_nxt_s;
            error_r   <= error_nxt_s;
            overrun_r <= overrun_nxt_s;
        end
    end

    assign req_out    = req_r;
    assign data_out   = data_r;
    assign data_oe    = oe_r;
    assign busy       = busy_r;
    assign tx_done    = done_r;
    assign tx_error   = error_r;
    assign tx_overrun = overrun_r;

endmodule

// File: tb/tb_interboard_tx_handshake.sv
module tb_interboard_tx_handshake;

    localparam int SETUP   = 4;
    localparam int TIMEOUT = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       transmit = 1'b0;
    logic       ctrl_en = 1'b0;
    logic       ctrl_move_dir = 1'b0;
    logic [4:0] ctrl_block_x = 5'd0;
    logic [2:0] ctrl_block_y = 3'd0;
    logic [3:0] ctrl_msg_type = 4'd0;
    logic [5:0] ctrl_card = 6'd0;
    logic [2:0] ctrl_sel_len = 3'd0;
    logic       ack_in;
    logic       req_out;
    logic [5:0] data_out;
    logic       data_oe;
    logic       busy;
    logic       tx_done;
    logic       tx_error;
    logic       tx_overrun;

    interboard_tx_handshake #(
        .SETUP_CYCLES   (SETUP),
        .TIMEOUT_CYCLES (TIMEOUT),
        .CHUNKS         (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .transmit      (transmit),
        .ctrl_en       (ctrl_en),
        .ctrl_move_dir (ctrl_move_dir),
        .ctrl_block_x  (ctrl_block_x),
        .ctrl_block_y  (ctrl_block_y),
        .ctrl_msg_type (ctrl_msg_type),
        .ctrl_card     (ctrl_card),
        .ctrl_sel_len  (ctrl_sel_len),
        .ack_in        (ack_in),
        .req_out       (req_out),
        .data_out      (data_out),
        .data_oe       (data_oe),
        .busy          (busy),
        .tx_done       (tx_done),
        .tx_error      (tx_error),
        .tx_overrun    (tx_overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]      msg_type;
        logic            en;
        logic            move_dir;
        logic [5:0]      card;
        logic [2:0]      block_y;
        logic [2:0]      sel_len;
        logic [4:0]      block_x;
        int              peer_dly;
        logic [0:3][5:0] exp_c;
    } vec_t;

    vec_t       vecs [4];
    logic [5:0] sb_q [$];
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         rise_cyc = 0;
    int         done_cnt = 0;
    int         err_cnt = 0;
    int         ovr_cnt = 0;
    int         peer_mode = 0;   // 0 follow req, 1 never ack, 2 ack stuck high
    int         peer_dly = 3;
    bit [63:0]  line = '0;
    logic       prev_req = 1'b0;
    logic [5:0] prev_data = 6'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input vec_t v, input int n);
        for (int i = 0; i < n; i++) sb_q.push_back(v.exp_c[i]);
    endtask

    task automatic drive_msg(input vec_t v);
        @(negedge clk);
        ctrl_msg_type = v.msg_type;
        ctrl_en       = v.en;
        ctrl_move_dir = v.move_dir;
        ctrl_card     = v.card;
        ctrl_block_y  = v.block_y;
        ctrl_sel_len  = v.sel_len;
        ctrl_block_x  = v.block_x;
        transmit      = 1'b1;
        @(negedge clk);
        transmit      = 1'b0;
    endtask

    task automatic wait_done(input string name, input int bound);
        int start;
        int k;
        start = done_cnt;
        k = 0;
        while (done_cnt == start && k < bound) begin
            @(negedge clk); #1;
            k++;
        end
        check({name, "_done_seen"}, 32'(done_cnt != start), 32'd1);
    endtask

    // cycle counter
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // peer model: Ack follows Request through a delay line
    initial begin
        ack_in = 1'b0;
        forever begin
            @(posedge clk); #1;
            line = {line[62:0], req_out};
            case (peer_mode)
                0:       ack_in = line[peer_dly-1];
                1:       ack_in = 1'b0;
                2:       ack_in = 1'b1;
                default: ack_in = 1'b0;
            endcase
        end
    end

    // scoreboard and pin-protocol monitor
    initial forever begin
        logic [5:0] exp;
        @(negedge clk);
        if (!rst) begin
            if (req_out && !prev_req) begin
                rise_cyc = cyc;
                check("sb_expected_pending", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    exp = sb_q.pop_front();
                    check("sb_chunk", 32'(data_out), 32'(exp));
                end
            end
            if (prev_req && req_out) check("data_stable_req_hi", 32'(data_out), 32'(prev_data));
            else if (req_out != prev_req) check("req_data_same_cycle", 32'(data_out), 32'(prev_data));
            if (tx_done)    done_cnt++;
            if (tx_error)   err_cnt++;
            if (tx_overrun) ovr_cnt++;
        end
        prev_req  = req_out;
        prev_data = data_out;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int d0;
        int e0;
        int o0;
        vec_t v;
        vecs[0] = '{4'h5, 1'b1, 1'b0, 6'd37, 3'd6, 3'd2, 5'd17, 3,
                    {6'b010110, 6'b100101, 6'b110010, 6'b100010}};
        vecs[1] = '{4'hF, 1'b1, 1'b1, 6'd63, 3'd7, 3'd7, 5'd31, 1,
                    {6'b111111, 6'b111111, 6'b111111, 6'b111110}};
        vecs[2] = '{4'h0, 1'b0, 1'b0, 6'd0, 3'd0, 3'd0, 5'd0, 50,
                    {6'b000000, 6'b000000, 6'b000000, 6'b000000}};
        vecs[3] = '{4'hA, 1'b0, 1'b1, 6'd42, 3'd5, 3'd0, 5'd10, 7,
                    {6'b101001, 6'b101010, 6'b101000, 6'b010100}};

        // reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_req",     32'(req_out),    32'd0);
        check("rst_data",    32'(data_out),   32'd0);
        check("rst_oe",      32'(data_oe),    32'd0);
        check("rst_busy",    32'(busy),       32'd0);
        check("rst_done",    32'(tx_done),    32'd0);
        check("rst_error",   32'(tx_error),   32'd0);
        check("rst_overrun", 32'(tx_overrun), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // table-driven messages, peers of varying speed
        for (int i = 0; i < 4; i++) begin
            peer_mode = 0;
            peer_dly  = vecs[i].peer_dly;
            d0 = done_cnt;
            e0 = err_cnt;
            push_exp(vecs[i], 4);
            drive_msg(vecs[i]);
            #1;
            check("lat_oe_cycle1", 32'(data_oe), 32'd1);
            check("lat_busy",      32'(busy),    32'd1);
            repeat (SETUP - 1) @(negedge clk);
            #1;
            check("lat_req_not_yet", 32'(req_out), 32'd0);
            @(negedge clk); #1;
            check("lat_req_rise", 32'(req_out), 32'd1);
            wait_done("vec", 2000);
            @(negedge clk); #1;
            check("vec_done_pulse_once", 32'(tx_done),        32'd0);
            check("vec_busy_low",        32'(busy),           32'd0);
            check("vec_oe_low",          32'(data_oe),        32'd0);
            check("vec_data_zero",       32'(data_out),       32'd0);
            check("vec_done_count",      32'(done_cnt - d0),  32'd1);
            check("vec_no_error",        32'(err_cnt - e0),   32'd0);
            check("vec_sb_empty",        32'(sb_q.size()),    32'd0);
            repeat (5) @(negedge clk);
        end

        // peer never acks: abort, then restart at chunk0
        peer_mode = 1;
        e0 = err_cnt;
        d0 = done_cnt;
        push_exp(vecs[0], 1);
        drive_msg(vecs[0]);
        k = 0;
        while (!tx_error && k < 300) begin
            @(negedge clk); #1;
            k++;
        end
        check("tout_error_seen",  32'(tx_error),       32'd1);
        check("tout_latency",     32'(cyc - rise_cyc), 32'(TIMEOUT));
        check("tout_req_low",     32'(req_out),        32'd0);
        @(negedge clk); #1;
        check("tout_error_pulse", 32'(tx_error), 32'd0);
        check("tout_oe_low",      32'(data_oe),  32'd0);
        check("tout_busy_low",    32'(busy),     32'd0);
        check("tout_err_count",   32'(err_cnt - e0),  32'd1);
        check("tout_no_done",     32'(done_cnt - d0), 32'd0);
        peer_mode = 0;
        peer_dly  = 3;
        repeat (5) @(negedge clk);
        push_exp(vecs[3], 4);
        drive_msg(vecs[3]);
        wait_done("tout_restart", 1000);
        repeat (3) @(negedge clk);

        // overrun during chunk1
        d0 = done_cnt;
        o0 = ovr_cnt;
        push_exp(vecs[0], 4);
        drive_msg(vecs[0]);
        k = 0;
        while (sb_q.size() > 2 && k < 300) begin
            @(negedge clk); #1;
            k++;
        end
        check("ovr_at_chunk1", 32'(sb_q.size()), 32'd2);
        v = vecs[1];
        drive_msg(v);
        #1;
        check("ovr_pulse", 32'(tx_overrun), 32'd1);
        @(negedge clk); #1;
        check("ovr_pulse_end", 32'(tx_overrun), 32'd0);
        wait_done("ovr", 1000);
        repeat (40) @(negedge clk);
        #1;
        check("ovr_one_done",    32'(done_cnt - d0), 32'd1);
        check("ovr_one_overrun", 32'(ovr_cnt - o0),  32'd1);
        check("ovr_sb_empty",    32'(sb_q.size()),   32'd0);
        check("ovr_idle",        32'(busy),          32'd0);

        // async reset during REQ_HI of chunk2
        d0 = done_cnt;
        e0 = err_cnt;
        push_exp(vecs[1], 4);
        drive_msg(vecs[1]);
        k = 0;
        while (sb_q.size() > 1 && k < 300) begin
            @(negedge clk); #1;
            k++;
        end
        check("arst_pre_req", 32'(req_out), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_req", 32'(req_out), 32'd0);
        check("arst_oe",  32'(data_oe), 32'd0);
        check("arst_busy", 32'(busy),   32'd0);
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        check("arst_no_done",  32'(done_cnt - d0), 32'd0);
        check("arst_no_error", 32'(err_cnt - e0),  32'd0);
        push_exp(vecs[3], 4);
        drive_msg(vecs[3]);
        wait_done("arst_restart", 1000);
        repeat (3) @(negedge clk);

        // Ack stuck high at start: SETUP waits for ack_s to fall
        peer_mode = 2;
        repeat (5) @(negedge clk);
        push_exp(vecs[0], 4);
        drive_msg(vecs[0]);
        repeat (20) @(negedge clk);
        #1;
        check("stuck_req_low", 32'(req_out),  32'd0);
        check("stuck_busy",    32'(busy),     32'd1);
        check("stuck_oe",      32'(data_oe),  32'd1);
        check("stuck_chunk0",  32'(data_out), 32'(vecs[0].exp_c[0]));
        peer_mode = 0;
        wait_done("stuck", 1000);
        repeat (3) @(negedge clk);
        #1;
        check("stuck_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/interboard_tx_handshake.md
Name: interboard_tx_handshake

Overview:
Transmit side of the board-to-board link. Latches one game-control message when `transmit` pulses and packs it into four 6-bit chunks. Sends each chunk over the shared Request/Ack/data pins using a four-phase handshake. Sits between the game-control outputs and the tri-state pin drivers in the interboard communication top; the receive path is a separate block.

Parameters:
SETUP_CYCLES, 4, clocks data_out is held stable before req_out rises
TIMEOUT_CYCLES, 1_000_000, clocks to wait on any Ack edge before aborting (10 ms at 100 MHz)
CHUNKS, 4, chunks per message (fixed; parameter for documentation only)

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  asynchronous, active-high reset
transmit  in  1  one-cycle pulse: send the ctrl_* fields
ctrl_en  in  1  message field
ctrl_move_dir  in  1  message field
ctrl_block_x  in  5  message field
ctrl_block_y  in  3  message field
ctrl_msg_type  in  4  message field
ctrl_card  in  6  message field
ctrl_sel_len  in  3  message field
ack_in  in  1  raw Ack pin input (asynchronous to clk)
req_out  out  1  Request pin drive value
data_out  out  6  interboard_data drive value
data_oe  out  1  high = this board drives Request and data pins
busy  out  1  high from the transmit latch until DONE or ABORT completes
tx_done  out  1  one-cycle pulse: all 4 chunks acknowledged
tx_error  out  1  one-cycle pulse: handshake timeout, message abandoned
tx_overrun  out  1  one-cycle pulse: transmit arrived while busy (request dropped)

Behaviour:
- Reset values: all outputs 0. FSM in IDLE; chunk index, counters and message register cleared; synchronizer flops cleared.
- The reset is asynchronous. Assertion mid-message immediately drops req_out and data_oe. No completion or error pulse is produced.
- ack_in passes through a 2-flop synchronizer. All decisions use ack_s, which is 2 clocks late relative to ack_in.
- Packing (MSB first), latched on the transmit cycle:
  - chunk0 = {msg_type[3:0], en, move_dir}
  - chunk1 = card[5:0]
  - chunk2 = {block_y[2:0], sel_len[2:0]}
  - chunk3 = {block_x[4:0], 1'b0}
- FSM states: IDLE, SETUP, REQ_HI, REQ_LO, DONE, ABORT.
- IDLE:
  - If transmit: latch the message, idx←0, busy←1, data_oe←1, data_out←chunk0, go to SETUP.
  - If ack_s=1 while in IDLE: stay in IDLE (the peer has not released Ack yet). Transmit is still accepted, and SETUP waits.
- SETUP:
  - Count SETUP_CYCLES clocks with data_out stable. The first count needs ack_s=0; while ack_s=1 the count holds at 0.
  - When the count is complete: req_out←1, go to REQ_HI.
- REQ_HI:
  - On ack_s=1: req_out←0, go to REQ_LO.
  - Timeout counter runs; when it reaches TIMEOUT_CYCLES, go to ABORT.
- REQ_LO:
  - On ack_s=0, if idx=3: go to DONE.
  - On ack_s=0 otherwise: idx←idx+1, data_out←next chunk, go to SETUP.
  - The timeout counter was cleared on entry and runs here as well.
- DONE: tx_done=1 for one cycle; busy←0, data_oe←0, data_out←0; go to IDLE.
- ABORT: tx_error=1 for one cycle; req_out←0, busy←0, data_oe←0, data_out←0; go to IDLE.
- Latency from the transmit pulse (cycle 0):
  - data_oe=1 at cycle 1.
  - req_out first rises at cycle 1+SETUP_CYCLES.
  - Minimum message time with an immediate peer: 4×(SETUP_CYCLES+2×(2 sync+1)) cycles.
- transmit while busy (any state except IDLE): request ignored, tx_overrun pulses the next cycle, the current message is unaffected.
- transmit in the same cycle as the DONE/ABORT state: treated as busy, so it is dropped with tx_overrun. busy deasserts one cycle later.
- req_out never changes in the same cycle as data_out.
- data_out changes only in IDLE→SETUP and REQ_LO→SETUP.
- Counter widths: $clog2(TIMEOUT_CYCLES+1) and $clog2(SETUP_CYCLES+1). Counters saturate and never wrap.

Decomposition:
- Shared package holds:
  - the FSM state enum
  - chunk field offsets and widths
  - CHUNKS=4
  - the message struct (en, move_dir, block_x, block_y, msg_type, card, sel_len), also used by the receiver for unpacking
- One sub-module, sync_2ff: 2-flop synchronizer with an asynchronous active-high reset to 0. It is reused by the receiver for Request.

Test Plan:
- Nominal message with an immediate peer (Ack follows Request after 3 clk):
  - Stimulus: transmit with msg_type=4'h5, en=1, move_dir=0, card=6'd37, block_y=3'd6, sel_len=3'd2, block_x=5'd17.
  - Required: data_out chunks 6'b010110, 6'b100101, 6'b110010, 6'b100010 in order, 4 req_out pulses, tx_done exactly once, busy low after it.
- Slow peer (Ack delayed 50 clk each edge): data_out stable for the whole time req_out is high, no tx_error, tx_done after the 4th Ack fall.
- Peer never acks (TIMEOUT_CYCLES=100 in bench): tx_error pulses 100 clk after req_out rises, req_out=0, data_oe=0, busy=0; a following transmit restarts at chunk0.
- Overrun: second transmit during chunk1 → tx_overrun one pulse, the first message completes unchanged, only one tx_done.
- Async reset during REQ_HI of chunk2: req_out, data_oe and busy drop without a clock edge; no tx_done/tx_error; a new message after reset sends chunk0 first.
- Ack stuck high at start: transmit latched, req_out does not rise until ack_s falls, then a normal send.
